dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port 256-word data memory (`dataMemory`). It shares the memory between the core load/store port (port 0) and a DMA/debug port (port 1), issuing at most one access per cycle. Before issuing, it rejects malformed requests: out of range, misaligned, or bad encoding. It returns registered read data or a write acknowledge one cycle after grant.

## Interface
Parameters:
- `STARVE_MAX`, 4: max consecutive port-0 grants while port 1 is waiting.
- `MEM_BYTES`, 1024: addressable byte range; must match 256 words × 4.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pN_req_valid`, in, 1 (N = 0, 1): request present; held stable until `pN_req_ready`.
- `pN_req_ready`, out, 1: request granted this cycle.
- `pN_req_we`, in, 1: 1 = store, 0 = load.
- `pN_req_s_sel`, in, 2: store size; 00 = byte, 01 = half, 10 = word.
- `pN_req_ld_sel`, in, 3: load type; 000 = lb, 001 = lh, 010 = lw, 011 = lbu, 100 = lhu.
- `pN_req_addr`, in, 32: byte address.
- `pN_req_wdata`, in, 32: store data.
- `pN_rsp_valid`, out, 1: one-cycle response pulse.
- `pN_rsp_rdata`, out, 32: load result; 0 for stores and errors.
- `pN_rsp_err`, out, 1: request rejected; no memory access was performed.
- `mem_we`, `mem_re`, out, 1: drive memory `MemWrite` and `MemRead`.
- `mem_s_sel`, out, 2; `mem_ld_sel`, out, 3; `mem_addr`, out, 32; `mem_wdata`, out, 32: forwarded from the granted port.
- `mem_rdata`, in, 32: memory `rd_data`; combinational within the grant cycle.

## Operation
- **Arbitration** is per-cycle and fixed-priority to port 0, with an anti-starvation override.
  - `starve_cnt` increments on each port-0 grant while `p1_req_valid` = 1.
  - `starve_cnt` clears on a port-1 grant, or on any cycle with `p1_req_valid` = 0.
  - When `starve_cnt` == `STARVE_MAX` and port 1 is valid, port 1 is granted.
  - The counter saturates and never wraps.
- **Grant is combinational.** `pN_req_ready` = grant_N. The requester may change its request only after the ready cycle.
- **Checks** run on the muxed request; any failure sets err:
  - `addr` ≥ `MEM_BYTES`.
  - Word access with `addr[1:0]` ≠ 0.
  - Half access with `addr[0]` ≠ 0.
  - Store with `s_sel` = 11.
  - Load with `ld_sel` > 100.
- **Issue** (granted and no error):
  - Store: `mem_we` = 1, `mem_re` = 0.
  - Load: `mem_re` = 1, `mem_we` = 0.
  - `mem_*` buses carry the granted request; when idle, they are all 0.
  - Error requests are still granted, but `mem_we` = `mem_re` = 0.
- **Response** is registered and goes to the granted port's `rsp_*` on the following cycle:
  - `rsp_valid` = 1.
  - `rsp_rdata` = `mem_rdata` for a good load, otherwise 0.
  - `rsp_err` = check result.
  - The other port's `rsp_valid` = 0, and its `rsp_rdata`/`rsp_err` hold their previous values.
- **No response backpressure:** requesters must sink every response.
- **Simultaneous valid:** exactly one grant; the loser's ready = 0 and its request is held.

## Timing
- Reset values:
  - `pN_rsp_valid` = 0, `pN_rsp_rdata` = 0, `pN_rsp_err` = 0, `starve_cnt` = 0.
  - While `rst` = 1: no grants, `pN_req_ready` = 0, `mem_we` = `mem_re` = 0.
- Store: memory write occurs on the grant-cycle edge; ack `rsp_valid` appears the next cycle.
- Load latency is 1 cycle: grant at cycle T, `rsp_rdata` valid at T+1.
- Throughput is one access per cycle; back-to-back grants to the same port are allowed.
- Reset asserted mid-operation: the pending response is dropped (`rsp_valid` = 0 at T+1). A store granted in the reset cycle is not issued.
- Store followed by a load to the same address in the next cycle returns the new data.

## Structure
- Package `dmem_pkg` holds:
  - `s_sel` constants: `SZ_B`, `SZ_H`, `SZ_W`.
  - `ld_sel` constants: `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`.
  - `MEM_BYTES`.
  - The request struct: `we`, `s_sel`, `ld_sel`, `addr`, `wdata`.
- Sub-module `dmem_req_check`: combinational legality check on one request, producing `err`. It is instantiated once, on the muxed request.
- Top level contains the grant logic, `starve_cnt`, and the response registers.

## Test plan
- Port 0 stores word 0xDEADBEEF at 0x10, then loads lw 0x10 → `p0_rsp_valid` at T+1 after each grant; load rdata = 0xDEADBEEF, err = 0.
- Both ports continuously valid, `STARVE_MAX` = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1; port-1 responses arrive in the slot after each of its grants.
- Port 1 requests lh at 0x3 → granted, `mem_re` = 0, rsp_err = 1, rdata = 0. Also lw at 0x400 → err = 1. Also store with `s_sel` = 11 → err = 1 and memory is unchanged.
- Memory word 1 preloaded with 0x000080F0; lb 0x4 → 0xFFFFFFF0, lbu 0x4 → 0x000000F0, lhu 0x4 → 0x000080F0, lh 0x4 → 0xFFFF80F0.
- `rst` asserted in the cycle after a port-0 load grant → no `rsp_valid`; all outputs are 0 after reset; the first post-reset grant goes to port 0 with `starve_cnt` = 0.
- Port 1 is valid alone for 10 cycles → granted every cycle; `starve_cnt` stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, memory size and request record for the data-memory arbiter.
package dmem_pkg;

  localparam int MEM_BYTES = 1024;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  typedef struct packed {
    logic        we;
    logic [1:0]  s_sel;
    logic [2:0]  ld_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_req_check.sv
// Legality check of one memory request: range, alignment and size/type encoding.
// Latency: purely combinational.
// Backpressure: none; err is valid whenever req is.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = dmem_pkg::MEM_BYTES
) (
  input  req_t req,
  output logic err
);

  logic out_of_range;
  logic is_word;
  logic is_half;
  logic bad_enc;
  logic unused_wdata;

  assign unused_wdata = ^req.wdata;

  always_comb begin
    out_of_range = (req.addr >= 32'(MEM_BYTES));
    // Store size and load type share no encoding, so decode by direction.
    if (req.we) begin
      is_word = (req.s_sel == SZ_W);
      is_half = (req.s_sel == SZ_H);
      bad_enc = (req.s_sel == 2'b11);
    end else begin
      is_word = (req.ld_sel == LD_W);
      is_half = (req.ld_sel == LD_H) || (req.ld_sel == LD_HU);
      bad_enc = (req.ld_sel > LD_HU);
    end
    err = out_of_range
        | (is_word & (|req.addr[1:0]))
        | (is_half & req.addr[0])
        | bad_enc;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Latency: grant combinational in the request cycle; response registered one cycle later.
// Backpressure: requests stall via req_ready; responses cannot be stalled.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int MEM_BYTES  = dmem_pkg::MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_s_sel,
  input  logic [2:0]  p0_req_ld_sel,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_s_sel,
  input  logic [2:0]  p1_req_ld_sel,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  mem_s_sel,
  output logic [2:0]  mem_ld_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starve_hit;
  logic          gnt0, gnt1, gnt_any;
  logic          chk_err;
  logic          good_load;
  logic          p0_vld_q, p1_vld_q;
  req_t          p0_req, p1_req, sel_req;

  always_comb begin
    p0_req = '{we: p0_req_we, s_sel: p0_req_s_sel, ld_sel: p0_req_ld_sel,
               addr: p0_req_addr, wdata: p0_req_wdata};
    p1_req = '{we: p1_req_we, s_sel: p1_req_s_sel, ld_sel: p1_req_ld_sel,
               addr: p1_req_addr, wdata: p1_req_wdata};
  end

  // Port 0 wins unless port 1 has already waited through STARVE_MAX port-0 grants.
  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
  assign gnt1       = !rst && p1_req_valid && (!p0_req_valid || starve_hit);
  assign gnt0       = !rst && p0_req_valid && !gnt1;
  assign gnt_any    = gnt0 || gnt1;
  assign sel_req    = gnt1 ? p1_req : p0_req;

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  dmem_req_check #(.MEM_BYTES(MEM_BYTES)) u_check (
    .req (sel_req),
    .err (chk_err)
  );

  assign good_load = gnt_any && !chk_err && !sel_req.we;

  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_s_sel  = '0;
    mem_ld_sel = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt_any) begin
      mem_we     = !chk_err && sel_req.we;
      mem_re     = !chk_err && !sel_req.we;
      mem_s_sel  = sel_req.s_sel;
      mem_ld_sel = sel_req.ld_sel;
      mem_addr   = sel_req.addr;
      mem_wdata  = sel_req.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      p0_vld_q     <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_vld_q     <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      if (!p1_req_valid || gnt1) begin
        starve_cnt <= '0;
      end else if (gnt0 && !starve_hit) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
      p0_vld_q <= gnt0;
      p1_vld_q <= gnt1;
      if (gnt0) begin
        p0_rsp_rdata <= good_load ? mem_rdata : '0;
        p0_rsp_err   <= chk_err;
      end
      if (gnt1) begin
        p1_rsp_rdata <= good_load ? mem_rdata : '0;
        p1_rsp_err   <= chk_err;
      end
    end
  end

  // A reset arriving the cycle after a grant must swallow that grant's response.
  assign p0_rsp_valid = p0_vld_q && !rst;
  assign p1_rsp_valid = p1_vld_q && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench with scoreboard and a behavioural 256-word memory for dmem_arbiter.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [1:0]  p0_req_s_sel;
  logic [2:0]  p0_req_ld_sel;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [1:0]  p1_req_s_sel;
  logic [2:0]  p1_req_ld_sel;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        mem_we, mem_re;
  logic [1:0]  mem_s_sel;
  logic [2:0]  mem_ld_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.STARVE_MAX(4), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_s_sel(p0_req_s_sel), .p0_req_ld_sel(p0_req_ld_sel), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_s_sel(p1_req_s_sel), .p1_req_ld_sel(p1_req_ld_sel), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_s_sel(mem_s_sel), .mem_ld_sel(mem_ld_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural dataMemory: combinational read with extension, write on the edge.
  logic [31:0] mem [256];
  logic [31:0] rword, rshift;

  always_comb begin
    rword  = mem[mem_addr[9:2]];
    rshift = rword >> {mem_addr[1:0], 3'b000};
    case (mem_ld_sel)
      LD_B:    mem_rdata = {{24{rshift[7]}}, rshift[7:0]};
      LD_H:    mem_rdata = {{16{rshift[15]}}, rshift[15:0]};
      LD_BU:   mem_rdata = {24'h0, rshift[7:0]};
      LD_HU:   mem_rdata = {16'h0, rshift[15:0]};
      default: mem_rdata = rword;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_s_sel)
        SZ_B:    mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
        SZ_H:    mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] = mem_wdata[15:0];
        default: mem[mem_addr[9:2]] = mem_wdata;
      endcase
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  s_sel;
    logic [2:0]  ld_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t        vecs[16];
  rsp_t        sb[$];
  logic [31:0] exp_rd[2];
  logic        exp_er[2];
  logic [31:0] hold_rdata[2];
  logic        hold_err[2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rsp_vld(input int q);
    return (q == 0) ? p0_rsp_valid : p1_rsp_valid;
  endfunction
  function automatic logic [31:0] rsp_rd(input int q);
    return (q == 0) ? p0_rsp_rdata : p1_rsp_rdata;
  endfunction
  function automatic logic rsp_er(input int q);
    return (q == 0) ? p0_rsp_err : p1_rsp_err;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic we, input logic [1:0] ss,
                         input logic [2:0] ls, input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd);
    if (p == 1'b0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_s_sel = ss; p0_req_ld_sel = ls;
      p0_req_addr = a; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_s_sel = ss; p1_req_ld_sel = ls;
      p1_req_addr = a; p1_req_wdata = wd;
    end
    exp_rd[p] = e_rd;
    exp_er[p] = e_err;
  endtask

  // Called at the falling edge: the response due from last cycle's grant, if any.
  task automatic check_rsp();
    rsp_t e;
    int   rp = -1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      rp = int'(e.port);
      chk($sformatf("p%0d_rsp_valid", rp), 32'(rsp_vld(rp)), 32'd1);
      chk($sformatf("p%0d_rsp_rdata", rp), rsp_rd(rp), e.rdata);
      chk($sformatf("p%0d_rsp_err", rp), 32'(rsp_er(rp)), 32'(e.err));
      hold_rdata[rp] = e.rdata;
      hold_err[rp]   = e.err;
    end
    for (int q = 0; q < 2; q++) begin
      if (q != rp) begin
        chk($sformatf("p%0d_rsp_idle", q), 32'(rsp_vld(q)), 32'd0);
        chk($sformatf("p%0d_rsp_hold_rdata", q), rsp_rd(q), hold_rdata[q]);
        chk($sformatf("p%0d_rsp_hold_err", q), 32'(rsp_er(q)), 32'(hold_err[q]));
      end
    end
  endtask

  // exp_g: 0 or 1 = port expected to win, 2 = no grant.
  task automatic observe(input int exp_g);
    #1;
    chk("p0_req_ready", 32'(p0_req_ready), 32'(exp_g == 0));
    chk("p1_req_ready", 32'(p1_req_ready), 32'(exp_g == 1));
    if (p0_req_ready)
      sb.push_back('{port: 1'b0, rdata: exp_rd[0], err: exp_er[0]});
    else if (p1_req_ready)
      sb.push_back('{port: 1'b1, rdata: exp_rd[1], err: exp_er[1]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // port, we, s_sel, ld_sel, addr, wdata, exp_err, exp_rdata
    vecs[0]  = '{1'b0, 1'b1, SZ_W,  LD_W,   32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, SZ_W,  LD_W,   32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, SZ_W,  LD_H,   32'h3,   32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, SZ_W,  LD_W,   32'h400, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, LD_W,   32'h10,  32'h12345678, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, SZ_W,  LD_W,   32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b0, SZ_W,  LD_B,   32'h4,   32'h0,        1'b0, 32'hFFFFFFF0};
    vecs[7]  = '{1'b0, 1'b0, SZ_W,  LD_BU,  32'h4,   32'h0,        1'b0, 32'h000000F0};
    vecs[8]  = '{1'b0, 1'b0, SZ_W,  LD_HU,  32'h4,   32'h0,        1'b0, 32'h000080F0};
    vecs[9]  = '{1'b0, 1'b0, SZ_W,  LD_H,   32'h4,   32'h0,        1'b0, 32'hFFFF80F0};
    vecs[10] = '{1'b1, 1'b0, SZ_W,  3'b101, 32'h8,   32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, SZ_H,  LD_W,   32'h5,   32'h0000BEEF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b1, SZ_B,  LD_W,   32'h3FF, 32'h000000AB, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, SZ_W,  LD_BU,  32'h3FF, 32'h0,        1'b0, 32'h000000AB};
    vecs[14] = '{1'b0, 1'b1, SZ_H,  LD_W,   32'h2,   32'h00001234, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, SZ_W,  LD_W,   32'h0,   32'h0,        1'b0, 32'h12340000};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h000080F0;
    for (int q = 0; q < 2; q++) begin
      hold_rdata[q] = 32'h0;
      hold_err[q]   = 1'b0;
    end

    // Reset with both ports requesting: nothing may be granted or issued.
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, SZ_W, LD_W, 32'h20, 32'h11111111, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, SZ_W, LD_W, 32'h4, 32'h0, 1'b0, 32'h000080F0);
    repeat (2) @(negedge clk);
    observe(2);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    check_rsp();
    rst = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;

    // Single-request vectors, issued back to back.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_rsp();
      set_req(vecs[i].port, 1'b1, vecs[i].we, vecs[i].s_sel, vecs[i].ld_sel,
              vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].port) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
      observe(int'(vecs[i].port));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(!vecs[i].exp_err && vecs[i].we));
      chk($sformatf("vec%0d_mem_re", i), 32'(mem_re), 32'(!vecs[i].exp_err && !vecs[i].we));
    end
    @(negedge clk);
    check_rsp();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    observe(2);
    chk("idle_mem_addr", mem_addr, 32'h0);

    // Both ports always valid: port 1 gets every fifth slot.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_rsp();
      set_req(1'b0, 1'b1, 1'b0, SZ_W, LD_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      set_req(1'b1, 1'b1, 1'b0, SZ_W, LD_W, 32'h4, 32'h0, 1'b0, 32'h000080F0);
      observe((k % 5 == 4) ? 1 : 0);
    end
    @(negedge clk);
    check_rsp();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    observe(2);

    // Reset the cycle after a port-0 load grant; a store offered during reset must not land.
    @(negedge clk);
    check_rsp();
    set_req(1'b0, 1'b1, 1'b0, SZ_W, LD_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    observe(0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    set_req(1'b0, 1'b1, 1'b1, SZ_W, LD_W, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, SZ_W, LD_W, 32'h4, 32'h0, 1'b0, 32'h000080F0);
    #1;
    chk("rst_drop_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    chk("rst_drop_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    chk("rst_store_mem_we", 32'(mem_we), 32'd0);
    chk("rst_p0_ready", 32'(p0_req_ready), 32'd0);
    @(negedge clk);
    for (int q = 0; q < 2; q++) begin
      hold_rdata[q] = 32'h0;
      hold_err[q]   = 1'b0;
    end
    check_rsp();
    chk("post_rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, SZ_W, LD_W, 32'h20, 32'h0, 1'b0, 32'h0);
    observe(0);
    @(negedge clk);
    check_rsp();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    observe(2);

    // Port 1 alone: granted every cycle, counter never moves.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_rsp();
      if (k % 2 == 0)
        set_req(1'b1, 1'b1, 1'b0, SZ_W, LD_W, 32'h4, 32'h0, 1'b0, 32'h000080F0);
      else
        set_req(1'b1, 1'b1, 1'b0, SZ_W, LD_BU, 32'h3FF, 32'h0, 1'b0, 32'h000000AB);
      observe(1);
      chk("p1_alone_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    end
    @(negedge clk);
    check_rsp();
    p1_req_valid = 1'b0;
    observe(2);
    @(negedge clk);
    check_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
